// File: rtl/sar_pkg.sv
// Shared definitions for the SAR sequencer: FSM state encoding and channel-search helper.
package sar_pkg;

    localparam int ST_W     = 3;
    localparam int SW_W_DEF = 4;
    localparam int MAX_CH   = 64;

    typedef enum logic [ST_W-1:0] {
        IDLE,
        SAMPLE,
        RST,
        START,
        CONV,
        DONE
    } state_t;

    // Index of the lowest set bit at or above 'from', or -1 if none.
    function automatic int next_set(input logic [MAX_CH-1:0] m, input int from);
        int r;
        r = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation trial register: one bit decided per step, MSB first.
module sar_bit_engine #(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            init,
    input  logic            step,
    input  logic            cmp,
    output logic [SIZE-1:0] trial,
    output logic            last
);

    logic [SIZE-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trial <= '0;
            ptr   <= '0;
        end else if (en) begin
            if (init) begin
                trial <= {1'b1, {(SIZE-1){1'b0}}};
                ptr   <= {1'b1, {(SIZE-1){1'b0}}};
            end else if (step) begin
                // keep or drop the bit under test, then raise the next one
                trial <= (cmp ? trial : (trial & ~ptr)) | (ptr >> 1);
                ptr   <= ptr >> 1;
            end
        end
    end

    assign last = ptr[0];

endmodule

// File: rtl/sar_seq_ctrl.sv
// Multi-channel SAR ADC controller with ascending channel scan and valid/ready output.
// Build macro SAR_AVG_EN adds avg_log2: 2^avg_log2 conversions averaged per channel.
//
// state  | meaning
// IDLE   | waiting for soc with a non-empty mask
// SAMPLE | one-cycle sample, mux settled on ch_sel
// RST    | hold + cap-DAC reset for swidth+1 cycles
// START  | DAC released, first trial applied
// CONV   | SIZE bit trials
// DONE   | result ready, pick next channel / repeat / stop
module sar_seq_ctrl
    import sar_pkg::*;
#(
    parameter  int SIZE = 12,
    parameter  int NCH  = 8,
    parameter  int SW_W = SW_W_DEF,
    localparam int CHW  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            soc,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [SW_W-1:0] swidth,
    input  logic            cmp,
    input  logic            data_ready,
    input  logic            ovr_clr,
`ifdef SAR_AVG_EN
    input  logic [1:0]      avg_log2,
`endif
    output logic            sample_n,
    output logic            dac_rst,
    output logic [CHW-1:0]  ch_sel,
    output logic [SIZE-1:0] data,
    output logic [CHW-1:0]  data_ch,
    output logic            data_valid,
    output logic            eoc,
    output logic            eos,
    output logic            busy,
    output logic            overrun
);

    state_t          state, state_nx;
    logic [SW_W-1:0] rcnt, rcnt_nx;
    logic [CHW-1:0]  ch_nx;
    logic [NCH-1:0]  mask_l, mask_nx;
    logic            deliver, final_conv, conv_last;
    logic [SIZE-1:0] trial, result;
    int              nxt_ch, low_ch;

    sar_bit_engine #(.SIZE(SIZE)) u_bits (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .init  (state == RST),
        .step  (state == CONV),
        .cmp   (cmp),
        .trial (trial),
        .last  (conv_last)
    );

    assign nxt_ch = next_set(MAX_CH'(mask_l), int'(ch_sel) + 1);
    assign low_ch = next_set(MAX_CH'(ch_mask), 0);

`ifdef SAR_AVG_EN
    logic [SIZE+2:0] acc, acc_sum;
    logic [2:0]      rep;

    assign acc_sum    = acc + (SIZE+3)'(trial);
    assign final_conv = (rep == 3'((4'd1 << avg_log2) - 4'd1));
    assign result     = SIZE'(acc_sum >> avg_log2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            rep <= '0;
        end else if (en && state == DONE) begin
            if (final_conv) begin
                acc <= '0;
                rep <= '0;
            end else begin
                acc <= acc_sum;
                rep <= rep + 3'd1;
            end
        end
    end
`else
    assign final_conv = 1'b1;
    assign result     = trial;
`endif

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        ch_nx    = ch_sel;
        mask_nx  = mask_l;
        deliver  = 1'b0;
        eos      = 1'b0;
        case (state)
            IDLE: begin
                if (soc && |ch_mask) begin
                    state_nx = SAMPLE;
                    mask_nx  = ch_mask;
                    ch_nx    = CHW'(low_ch);
                end
            end
            SAMPLE: state_nx = RST;
            RST: begin
                if (rcnt == swidth) begin
                    state_nx = START;
                    rcnt_nx  = '0;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
            end
            START: state_nx = CONV;
            CONV: if (conv_last) state_nx = DONE;
            DONE: begin
                if (!final_conv) begin
                    state_nx = SAMPLE;
                end else begin
                    deliver = 1'b1;
                    if (nxt_ch >= 0) begin
                        state_nx = SAMPLE;
                        ch_nx    = CHW'(nxt_ch);
                    end else begin
                        eos = 1'b1;
                        // continuous mode re-reads the live mask for the next scan
                        if (cont && |ch_mask) begin
                            state_nx = SAMPLE;
                            mask_nx  = ch_mask;
                            ch_nx    = CHW'(low_ch);
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rcnt       <= '0;
            ch_sel     <= '0;
            mask_l     <= '0;
            data       <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (en) begin
            state  <= state_nx;
            rcnt   <= rcnt_nx;
            ch_sel <= ch_nx;
            mask_l <= mask_nx;
            if (deliver) begin
                data       <= result;
                data_ch    <= ch_sel;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            overrun <= (deliver && data_valid && !data_ready) || (overrun && !ovr_clr);
        end
    end

    assign sample_n = !(state == SAMPLE || state == RST);
    assign dac_rst  = (state == RST) || (state == START);
    assign eoc      = (state == DONE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: ideal comparator stub plus scan/latency reference model.
module tb_sar_seq_ctrl;

    localparam int SIZE = 12;
    localparam int NCH  = 8;
    localparam int SW_W = 4;
    localparam int CHW  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            soc = 1'b0;
    logic            cont = 1'b0;
    logic [NCH-1:0]  ch_mask = '0;
    logic [SW_W-1:0] swidth = '0;
    logic            cmp;
    logic            data_ready = 1'b0;
    logic            ovr_clr = 1'b0;
`ifdef SAR_AVG_EN
    logic [1:0]      avg_log2 = 2'd0;
`endif
    logic            sample_n, dac_rst, data_valid, eoc, eos, busy, overrun;
    logic [CHW-1:0]  ch_sel, data_ch;
    logic [SIZE-1:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    sar_seq_ctrl #(.SIZE(SIZE), .NCH(NCH), .SW_W(SW_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .soc        (soc),
        .cont       (cont),
        .ch_mask    (ch_mask),
        .swidth     (swidth),
        .cmp        (cmp),
        .data_ready (data_ready),
        .ovr_clr    (ovr_clr),
`ifdef SAR_AVG_EN
        .avg_log2   (avg_log2),
`endif
        .sample_n   (sample_n),
        .dac_rst    (dac_rst),
        .ch_sel     (ch_sel),
        .data       (data),
        .data_ch    (data_ch),
        .data_valid (data_valid),
        .eoc        (eoc),
        .eos        (eos),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Ideal comparator: the i-th bit trial of a conversion answers with bit SIZE-1-i of the analog code.
    logic [SIZE-1:0] code_tab [NCH];
    logic [SIZE-1:0] seq_codes [4];
    logic [SIZE-1:0] cur_code;
    bit              use_seq = 1'b0;
    int              raw_base = 0;
    int              raw_n = 0;
    int              cidx = SIZE;

    always @(posedge clk) begin
        if (en) begin
            if (dac_rst && sample_n) cidx <= 0;
            else if (cidx < SIZE)    cidx <= cidx + 1;
            if (eoc) raw_n <= raw_n + 1;
        end
    end

    always_comb begin
        cur_code = use_seq ? seq_codes[(raw_n - raw_base) & 3] : code_tab[ch_sel];
        cmp      = (cidx < SIZE) ? cur_code[SIZE-1-cidx] : 1'b0;
    end

    typedef struct {
        logic [SIZE-1:0] d;
        logic [CHW-1:0]  ch;
        int              cyc;
    } res_t;

    res_t           got_q[$];
    int             eos_q[$];
    logic [CHW-1:0] chs_q[$];
    int             eoc_n;
    bit             timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one scan from soc and records results, eos and ch_sel changes by cycle after the soc edge.
    task automatic run_scan(input logic [NCH-1:0] m, input int sw, input int budget, input bit extra_soc);
        bit   vprev, rprev;
        res_t r;
        got_q.delete();
        eos_q.delete();
        chs_q.delete();
        eoc_n     = 0;
        timed_out = 1'b1;
        vprev     = 1'b0;
        rprev     = 1'b1;
        ch_mask   = m;
        swidth    = SW_W'(sw);
        soc       = 1'b1;
        tick();
        soc = 1'b0;
        for (int n = 0; n <= budget; n++) begin
            if (busy && (chs_q.size() == 0 || chs_q[$] !== ch_sel)) chs_q.push_back(ch_sel);
            if (eos) eos_q.push_back(n);
            if (eoc) eoc_n++;
            if (data_valid && (!vprev || rprev)) begin
                r.d = data; r.ch = data_ch; r.cyc = n;
                got_q.push_back(r);
            end
            vprev = data_valid;
            rprev = data_ready;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            soc = extra_soc && (n == 5);
            tick();
        end
        soc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({sample_n, dac_rst, busy, data_valid, eoc, eos, overrun} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 1000000", {sample_n, dac_rst, busy, data_valid, eoc, eos, overrun});
        end
        n_checks++;
        if ({data, data_ch, ch_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h data_ch=%0d ch_sel=%0d expected zeros", data, data_ch, ch_sel);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int n, eos_cnt;
        code_tab[0] = 12'hA5C;
        data_ready = 1'b0;
        ch_mask = 8'h01; swidth = 4'd2;
        soc = 1'b1; tick(); soc = 1'b0;
        n = 0; eos_cnt = 0;
        while (!data_valid && n < 100) begin
            if (eos) eos_cnt++;
            tick(); n++;
        end
        n_checks++;
        if (n != 18) begin n_fail++; $display("FAIL single_latency: got %0d cycles expected 18", n); end
        n_checks++;
        if (data !== 12'hA5C || data_ch !== 3'd0) begin
            n_fail++;
            $display("FAIL single_data: got %h ch %0d expected a5c ch 0", data, data_ch);
        end
        n_checks++;
        if (eos_cnt != 1) begin n_fail++; $display("FAIL single_eos: got %0d pulses expected 1", eos_cnt); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b expected 0", busy); end
        data_ready = 1'b1; tick();
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_ready_clear: valid=%b expected 0", data_valid); end
    endtask

    task automatic test_multi();
        logic [CHW-1:0] exp_ch [3];
        logic [SIZE-1:0] exp_d [3];
        exp_ch = '{3'd0, 3'd2, 3'd5};
        exp_d  = '{12'h001, 12'h800, 12'hFFF};
        code_tab[0] = 12'h001; code_tab[2] = 12'h800; code_tab[5] = 12'hFFF;
        data_ready = 1'b1;
        run_scan(8'h25, 1, 300, 1'b1);
        n_checks++;
        if (timed_out || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL multi_count: got %0d results timeout=%0d expected 3", got_q.size(), timed_out);
        end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k].d !== exp_d[k] || got_q[k].ch !== exp_ch[k] || got_q[k].cyc != (k + 1) * 17) begin
                n_fail++;
                $display("FAIL multi_result%0d: got %h ch %0d at %0d expected %h ch %0d at %0d",
                         k, got_q[k].d, got_q[k].ch, got_q[k].cyc, exp_d[k], exp_ch[k], (k + 1) * 17);
            end
        end
        n_checks++;
        if (chs_q.size() != 3 || chs_q[0] !== 3'd0 || chs_q[1] !== 3'd2 || chs_q[2] !== 3'd5) begin
            n_fail++;
            $display("FAIL multi_ch_sel: got %p expected 0 2 5", chs_q);
        end
        n_checks++;
        if (eos_q.size() != 1 || eos_q[0] != 3 * 17 - 1) begin
            n_fail++;
            $display("FAIL multi_eos: got %p expected single pulse at 50", eos_q);
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] m;
        int sw, len, k;
        data_ready = 1'b1;
        for (int it = 0; it < 10; it++) begin
            m  = NCH'($urandom_range(1, 255));
            sw = $urandom_range(0, 7);
            for (int c = 0; c < NCH; c++) code_tab[c] = SIZE'($urandom_range(0, 4095));
            len = SIZE + sw + 4;
            run_scan(m, sw, 600, (it % 2) == 1);
            n_checks++;
            if (timed_out || got_q.size() != $countones(m)) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d timeout=%0d expected %0d", it, got_q.size(), timed_out, $countones(m));
            end
            k = 0;
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    if (k < got_q.size()) begin
                        n_checks++;
                        if (got_q[k].d !== code_tab[c] || got_q[k].ch !== CHW'(c) || got_q[k].cyc != (k + 1) * len) begin
                            n_fail++;
                            $display("FAIL rand%0d_result%0d: got %h ch %0d at %0d expected %h ch %0d at %0d",
                                     it, k, got_q[k].d, got_q[k].ch, got_q[k].cyc, code_tab[c], c, (k + 1) * len);
                        end
                    end
                    k++;
                end
            end
            n_checks++;
            if (eos_q.size() != 1 || eos_q[0] != k * len - 1) begin
                n_fail++;
                $display("FAIL rand%0d_eos: got %p expected one pulse at %0d", it, eos_q, k * len - 1);
            end
        end
    endtask

    task automatic test_overrun();
        logic [SIZE-1:0] c1, c2, c3;
        c1 = SIZE'($urandom_range(0, 4095));
        c2 = c1 ^ 12'h5A5;
        c3 = c1 ^ 12'hA3C;
        code_tab[1] = c1;
        cont = 1'b1; ch_mask = 8'h02; swidth = 4'd1;
        data_ready = 1'b1; tick();
        data_ready = 1'b0;
        soc = 1'b1; tick(); soc = 1'b0;
        repeat (17) tick();
        n_checks++;
        if (data_valid !== 1'b1 || overrun !== 1'b0 || data !== c1 || data_ch !== 3'd1) begin
            n_fail++;
            $display("FAIL ovr_first: valid=%b ovr=%b data=%h ch=%0d expected 1 0 %h 1", data_valid, overrun, data, data_ch, c1);
        end
        code_tab[1] = c2;
        repeat (17) tick();
        n_checks++;
        if (overrun !== 1'b1 || data !== c2) begin
            n_fail++;
            $display("FAIL ovr_second: ovr=%b data=%h expected 1 %h", overrun, data, c2);
        end
        code_tab[1] = c3;
        cont = 1'b0;
        repeat (16) tick();
        ovr_clr = 1'b1;
        tick();
        n_checks++;
        if (overrun !== 1'b1 || data !== c3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_set_wins: ovr=%b data=%h busy=%b expected 1 %h 0", overrun, data, busy, c3);
        end
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: ovr=%b expected 0", overrun); end
        data_ready = 1'b1; tick();
        data_ready = 1'b0;
    endtask

    task automatic test_en_freeze();
        int n;
        code_tab[0] = SIZE'($urandom_range(0, 4095));
        ch_mask = 8'h01; swidth = 4'd2;
        soc = 1'b1; tick(); soc = 1'b0;
        n = 0;
        repeat (9) begin tick(); n++; end
        en = 1'b0;
        repeat (5) begin tick(); n++; end
        en = 1'b1;
        while (!data_valid && n < 200) begin tick(); n++; end
        n_checks++;
        if (n != 23) begin n_fail++; $display("FAIL freeze_latency: got %0d cycles expected 23", n); end
        n_checks++;
        if (data !== code_tab[0]) begin n_fail++; $display("FAIL freeze_data: got %h expected %h", data, code_tab[0]); end
    endtask

    task automatic test_reset_mid();
        ch_mask = 8'h01; swidth = 4'd3;
        soc = 1'b1; tick(); soc = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sample_n, busy, data_valid, dac_rst} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid: sample_n/busy/valid/dac_rst=%b expected 1000", {sample_n, busy, data_valid, dac_rst});
        end
        tick();
        rst_n = 1'b1;
        tick();
        ch_mask = '0;
        soc = 1'b1; tick(); soc = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sample_n !== 1'b1) begin
            n_fail++;
            $display("FAIL soc_mask0: busy=%b sample_n=%b expected 0 1", busy, sample_n);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL soc_mask0_later: busy=%b valid=%b expected 0 0", busy, data_valid);
        end
    endtask

`ifdef SAR_AVG_EN
    task automatic test_avg();
        seq_codes = '{12'd10, 12'd11, 12'd12, 12'd13};
        avg_log2 = 2'd2;
        data_ready = 1'b1;
        tick();
        raw_base = raw_n;
        use_seq = 1'b1;
        run_scan(8'h01, 0, 400, 1'b0);
        use_seq = 1'b0;
        avg_log2 = 2'd0;
        n_checks++;
        if (eoc_n != 4) begin n_fail++; $display("FAIL avg_eoc: got %0d pulses expected 4", eoc_n); end
        n_checks++;
        if (timed_out || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL avg_count: got %0d results expected 1", got_q.size());
        end else if (got_q[0].d !== 12'd11 || got_q[0].cyc != 4 * 16) begin
            n_fail++;
            $display("FAIL avg_data: got %0d at %0d expected 11 at 64", got_q[0].d, got_q[0].cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_random();
        test_overrun();
        test_en_freeze();
        test_reset_mid();
`ifdef SAR_AVG_EN
        test_avg();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_seq_ctrl.md
Name: sar_seq_ctrl

Overview:
Multi-channel, parametrised-width SAR ADC controller with a channel sequencer.
- Converts every channel enabled in a channel mask, in ascending index order, once per start-of-conversion.
- Optional continuous mode restarts the scan automatically.
- Drives the analog mux select, sample/hold and capacitive-DAC reset, and runs the bit-trial SAR.
- Delivers channel-tagged results over a valid/ready interface with overrun detection.
- Sits between the register-interface wrapper and the analog comparator/DAC macro.

Parameters:
SIZE, 12, conversion resolution in bits (>=4)
NCH, 8, number of analog channels (>=2)
SW_W, 4, width of the sample-width field
CHW, $clog2(NCH), channel index width (derived, not overridable)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state and outputs
soc  in  1  start of conversion sequence
cont  in  1  continuous mode: rescan after end of sequence
ch_mask  in  NCH  channels to convert in a sequence
swidth  in  SW_W  sample time; hold phase lasts swidth+1 cycles
cmp  in  1  analog comparator output
data_ready  in  1  consumer accepts data
ovr_clr  in  1  clears sticky overrun
sample_n  out  1  low while sampling (SAMPLE, RST)
dac_rst  out  1  high in RST and START
ch_sel  out  CHW  analog mux select for the current channel
data  out  SIZE  latest result
data_ch  out  CHW  channel of data
data_valid  out  1  result pending
eoc  out  1  one-cycle pulse in DONE, per raw conversion
eos  out  1  one-cycle pulse in DONE of the last channel of a sequence
busy  out  1  state != IDLE
overrun  out  1  sticky: result lost

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low.
  - Reset values: state IDLE; all outputs 0 except sample_n=1.
  - Reset mid-conversion aborts immediately; no partial result is delivered.
- en low: all registers hold, including the handshake registers.
- States and transitions:
  - IDLE -> SAMPLE when soc=1 and ch_mask!=0. On this edge, ch_mask is latched and ch_sel takes the lowest set bit. soc with mask==0 is ignored.
  - SAMPLE (1 cycle) -> RST.
  - RST: counter runs 0..swidth, then START; the counter clears on exit.
  - START (1 cycle) -> CONV.
  - CONV (SIZE cycles) -> DONE.
  - DONE:
    - -> SAMPLE with ch_sel = next higher set bit of the latched mask, if one exists.
    - Otherwise eos=1, then: cont=1 -> SAMPLE, re-latching the live ch_mask from its lowest set bit (IDLE if the mask is now 0); cont=0 -> IDLE.
- soc while busy is ignored.
- SAR bit trial:
  - In RST, trial = 1<<(SIZE-1).
  - Each CONV cycle at bit position k: bit k is kept if cmp=1, else cleared; bit k-1 is set.
  - The LSB is decided on the last CONV cycle.
- Latency: soc sampled at edge t0 -> data_valid rises at t0+SIZE+swidth+4. Each additional channel adds SIZE+swidth+4 cycles.
- Output handshake:
  - On the DONE exit edge: data, data_ch loaded and data_valid=1.
  - data_valid clears on data_ready=1 unless a new result loads on the same edge; in that case valid stays 1 and there is no overrun.
  - New result while data_valid=1 and data_ready=0: data is overwritten and overrun is set.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur on the same edge, set wins.

Optional Feature:
SAR_AVG_EN
- Defined: adds input avg_log2 [1:0]. Each channel is converted 2^avg_log2 times back to back (SAMPLE..DONE each time) into a SIZE+3-bit accumulator.
  - Result = acc >> avg_log2, truncated.
  - eoc pulses on every raw conversion; data_valid, eos and the channel advance occur only after the last one.
- Undefined: avg_log2 port absent; one conversion per channel.

Decomposition:
- Package sar_pkg: state localparams (IDLE, SAMPLE, RST, START, CONV, DONE), state width, SW_W default, helper for lowest-set-bit-above-index.
- One sub-module, sar_bit_engine: shift/trial registers, per-bit cmp decision and done flag; parameter SIZE.

Test Plan:
- SIZE=12, swidth=2, mask=0x01, comparator model with code 0xA5C -> data=0xA5C, data_ch=0, data_valid rises 18 cycles after soc edge, eos once.
- mask=0x25, codes ch0=0x001, ch2=0x800, ch5=0xFFF, data_ready=1 -> three results tagged 0, 2, 5 in order; ch_sel 0->2->5; eos only after ch5.
- cont=1, mask=0x02, data_ready=0 -> second result sets overrun, data holds newest; ovr_clr pulse -> overrun=0.
- en low for 5 cycles mid-CONV -> result identical to an uninterrupted run, conversion time +5 cycles.
- rst_n asserted mid-RST -> sample_n=1, busy=0, data_valid=0 immediately; soc with mask=0 -> stays IDLE.
- SAR_AVG_EN, avg_log2=2, codes 10, 11, 12, 13 -> 4 eoc pulses, one data_valid, data=11.
